// File: rtl/state_var_sequencer.sv
// state_var_sequencer: fetches initial words, steps through compute phases over the shared
// arithmetic units, writes result words back and pulses completion.
module state_var_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_INIT_VAL   = 6,
  parameter int NUM_EVAL_VAL   = 3,
  parameter int NUM_PHASES     = 3,
  parameter int NUM_ADD        = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int AW = $clog2(NUM_INIT_VAL + NUM_EVAL_VAL)
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     start,
  output logic [AW-1:0]                            mem_state_var_addr,
  input  logic [DATA_WIDTH-1:0]                    mem_state_var_data_out,
  output logic [DATA_WIDTH-1:0]                    mem_state_var_data_in,
  output logic                                     mem_state_var_we,
  output logic [NUM_INIT_VAL*DATA_WIDTH-1:0]       init_val,
  output logic [NUM_PHASES-1:0]                    phase_start,
  input  logic [NUM_PHASES-1:0]                    phase_done,
  input  logic [NUM_PHASES*NUM_ADD*DATA_WIDTH-1:0] ph_add_a,
  input  logic [NUM_PHASES*NUM_ADD*DATA_WIDTH-1:0] ph_add_b,
  input  logic [NUM_PHASES*NUM_ADD-1:0]            ph_add_start,
  input  logic [NUM_PHASES*DATA_WIDTH-1:0]         ph_mult_a,
  input  logic [NUM_PHASES*DATA_WIDTH-1:0]         ph_mult_b,
  input  logic [NUM_PHASES*DATA_WIDTH-1:0]         ph_exp_a,
  input  logic [NUM_PHASES*DATA_WIDTH-1:0]         ph_exp_b,
  input  logic [NUM_PHASES-1:0]                    ph_mult_start,
  input  logic [NUM_PHASES-1:0]                    ph_exp_start,
  input  logic [NUM_PHASES-1:0]                    ph_div_start,
  output logic [NUM_ADD*DATA_WIDTH-1:0]            add_a,
  output logic [NUM_ADD*DATA_WIDTH-1:0]            add_b,
  output logic [NUM_ADD-1:0]                       add_start,
  output logic [DATA_WIDTH-1:0]                    mult_a,
  output logic [DATA_WIDTH-1:0]                    mult_b,
  output logic [DATA_WIDTH-1:0]                    exp_a,
  output logic [DATA_WIDTH-1:0]                    exp_b,
  output logic                                     mult_start,
  output logic                                     exp_start,
  output logic                                     div_start,
  input  logic [NUM_EVAL_VAL*DATA_WIDTH-1:0]       result_val,
  output logic                                     busy,
  output logic                                     data_ready,
  output logic                                     timeout_err
);
  localparam int DW = DATA_WIDTH;
  localparam int LW = NUM_ADD * DATA_WIDTH;
  localparam int CW = $clog2((NUM_INIT_VAL > NUM_EVAL_VAL ? NUM_INIT_VAL : NUM_EVAL_VAL) + 1);
  localparam int PW = NUM_PHASES > 1 ? $clog2(NUM_PHASES) : 1;
  localparam int WW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit WD_ON = TIMEOUT_CYCLES != 0;
  typedef enum logic [2:0] {IDLE, FETCH, PH_START, PH_WAIT, WRITEBACK, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [PW-1:0] p;
  logic [WW-1:0] wd;
  logic done_p, expired, last_p, route_en;
  assign done_p  = phase_done[p];
  assign last_p  = p == PW'(NUM_PHASES - 1);
  assign expired = WD_ON && wd == WD_LAST;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = start ? FETCH : IDLE;
      FETCH:     state_n = cnt == CW'(NUM_INIT_VAL) ? PH_START : FETCH;
      PH_START:  state_n = PH_WAIT;
      PH_WAIT:   state_n = done_p ? (last_p ? WRITEBACK : PH_START) : expired ? DONE : PH_WAIT;
      WRITEBACK: state_n = cnt == CW'(NUM_EVAL_VAL - 1) ? DONE : WRITEBACK;
      default:   state_n = IDLE;
    endcase
  end
  // cnt serves as the fetch counter and then, cleared at the end of fetch, as the write-back index
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      p           <= '0;
      wd          <= '0;
      timeout_err <= 1'b0;
      init_val    <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          cnt         <= '0;
          p           <= '0;
          wd          <= '0;
          timeout_err <= 1'b0;
        end
        FETCH: begin
          if (cnt != '0) init_val[(int'(cnt) - 1)*DW +: DW] <= mem_state_var_data_out;
          cnt <= cnt == CW'(NUM_INIT_VAL) ? '0 : cnt + 1'b1;
          p   <= '0;
        end
        PH_START: wd <= '0;
        PH_WAIT: begin
          wd <= wd + 1'b1;
          if (done_p && !last_p) p <= p + 1'b1;
          if (!done_p && expired) timeout_err <= 1'b1;
        end
        WRITEBACK: cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end
  assign busy                  = state != IDLE;
  assign data_ready            = state == DONE;
  assign mem_state_var_we      = state == WRITEBACK;
  assign mem_state_var_addr    = state == WRITEBACK ? AW'(NUM_INIT_VAL) + AW'(cnt) :
                                 (state == FETCH && cnt < CW'(NUM_INIT_VAL)) ? AW'(cnt) : '0;
  assign mem_state_var_data_in = state == WRITEBACK ? result_val[int'(cnt)*DW +: DW] : '0;
  assign phase_start           = state == PH_START ? NUM_PHASES'(1) << p : '0;
  assign route_en   = state == PH_START || state == PH_WAIT;
  assign add_a      = route_en ? ph_add_a[int'(p)*LW +: LW] : '0;
  assign add_b      = route_en ? ph_add_b[int'(p)*LW +: LW] : '0;
  assign add_start  = route_en ? ph_add_start[int'(p)*NUM_ADD +: NUM_ADD] : '0;
  assign mult_a     = route_en ? ph_mult_a[int'(p)*DW +: DW] : '0;
  assign mult_b     = route_en ? ph_mult_b[int'(p)*DW +: DW] : '0;
  assign exp_a      = route_en ? ph_exp_a[int'(p)*DW +: DW] : '0;
  assign exp_b      = route_en ? ph_exp_b[int'(p)*DW +: DW] : '0;
  assign mult_start = route_en && ph_mult_start[p];
  assign exp_start  = route_en && ph_exp_start[p];
  assign div_start  = route_en && ph_div_start[p];
endmodule

// File: tb/tb_state_var_sequencer.sv
// tb_state_var_sequencer: randomized runs against a schedule model derived from phase wait lengths.
`timescale 1ns/1ps
module tb_state_var_sequencer;
  localparam int DW = 32, NI = 6, NE = 3, NP = 3, NA = 2, TO = 8;
  localparam int AW = $clog2(NI + NE);
  localparam int RW = 2*NA*DW + NA + 4*DW + 3;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  always #5 clock = ~clock;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata, wdata;
  logic we, busy, data_ready, timeout_err;
  logic [NI*DW-1:0] init_val;
  logic [NP-1:0] phase_start, phase_done;
  logic [NP*NA*DW-1:0] ph_add_a, ph_add_b;
  logic [NP*NA-1:0] ph_add_start;
  logic [NP*DW-1:0] ph_mult_a, ph_mult_b, ph_exp_a, ph_exp_b;
  logic [NP-1:0] ph_mult_start, ph_exp_start, ph_div_start;
  logic [NA*DW-1:0] add_a, add_b;
  logic [NA-1:0] add_start;
  logic [DW-1:0] mult_a, mult_b, exp_a, exp_b;
  logic mult_start, exp_start, div_start;
  logic [NE*DW-1:0] result_val;
  logic [RW-1:0] rgot;
  assign rgot = {add_a, add_b, add_start, mult_a, mult_b, exp_a, exp_b, mult_start, exp_start, div_start};
  logic start2 = 1'b0, a2, we2, pd2, busy2, dr2, te2, ms2, es2, ds2;
  logic [0:0] ps2;
  logic [DW-1:0] rdata2, wdata2, init2, res2, m2a, m2b, e2a, e2b;
  logic [4*DW-1:0] pa2, pb2, add_a2, add_b2;
  logic [3:0] pas2, add_start2;
  logic [DW-1:0] mem [NI];
  logic [DW-1:0] res [NE];
  int wlen [NP];
  int n_tests = 0, n_fail = 0;

  state_var_sequencer #(.DATA_WIDTH(DW), .NUM_INIT_VAL(NI), .NUM_EVAL_VAL(NE), .NUM_PHASES(NP),
    .NUM_ADD(NA), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .mem_state_var_addr(addr),
    .mem_state_var_data_out(rdata), .mem_state_var_data_in(wdata), .mem_state_var_we(we),
    .init_val(init_val), .phase_start(phase_start), .phase_done(phase_done),
    .ph_add_a(ph_add_a), .ph_add_b(ph_add_b), .ph_add_start(ph_add_start),
    .ph_mult_a(ph_mult_a), .ph_mult_b(ph_mult_b), .ph_exp_a(ph_exp_a), .ph_exp_b(ph_exp_b),
    .ph_mult_start(ph_mult_start), .ph_exp_start(ph_exp_start), .ph_div_start(ph_div_start),
    .add_a(add_a), .add_b(add_b), .add_start(add_start), .mult_a(mult_a), .mult_b(mult_b),
    .exp_a(exp_a), .exp_b(exp_b), .mult_start(mult_start), .exp_start(exp_start),
    .div_start(div_start), .result_val(result_val), .busy(busy), .data_ready(data_ready),
    .timeout_err(timeout_err));

  state_var_sequencer #(.DATA_WIDTH(DW), .NUM_INIT_VAL(1), .NUM_EVAL_VAL(1), .NUM_PHASES(1),
    .NUM_ADD(4)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .mem_state_var_addr(a2),
    .mem_state_var_data_out(rdata2), .mem_state_var_data_in(wdata2), .mem_state_var_we(we2),
    .init_val(init2), .phase_start(ps2), .phase_done(pd2),
    .ph_add_a(pa2), .ph_add_b(pb2), .ph_add_start(pas2),
    .ph_mult_a(res2), .ph_mult_b(res2), .ph_exp_a(res2), .ph_exp_b(res2),
    .ph_mult_start(pd2), .ph_exp_start(pd2), .ph_div_start(pd2),
    .add_a(add_a2), .add_b(add_b2), .add_start(add_start2), .mult_a(m2a), .mult_b(m2b),
    .exp_a(e2a), .exp_b(e2b), .mult_start(ms2), .exp_start(es2),
    .div_start(ds2), .result_val(res2), .busy(busy2), .data_ready(dr2),
    .timeout_err(te2));

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // what the shared units should see while phase k owns them; k < 0 means nobody does
  function automatic logic [RW-1:0] route(input int k);
    logic [NA*DW-1:0] aa, ab;
    logic [NA-1:0] as;
    if (k < 0) return '0;
    for (int l = 0; l < NA; l++) begin
      aa[l*DW +: DW] = ph_add_a[(k*NA + l)*DW +: DW];
      ab[l*DW +: DW] = ph_add_b[(k*NA + l)*DW +: DW];
      as[l] = ph_add_start[k*NA + l];
    end
    return {aa, ab, as, ph_mult_a[k*DW +: DW], ph_mult_b[k*DW +: DW], ph_exp_a[k*DW +: DW],
            ph_exp_b[k*DW +: DW], ph_mult_start[k], ph_exp_start[k], ph_div_start[k]};
  endfunction

  task automatic rand_all();
    logic [31:0] r;
    for (int i = 0; i < NI; i++) mem[i] = $urandom;
    for (int i = 0; i < NE; i++) res[i] = $urandom;
    for (int i = 0; i < NP*NA; i++) begin
      ph_add_a[i*DW +: DW] = $urandom;
      ph_add_b[i*DW +: DW] = $urandom;
    end
    for (int i = 0; i < NP; i++) begin
      ph_mult_a[i*DW +: DW] = $urandom;
      ph_mult_b[i*DW +: DW] = $urandom;
      ph_exp_a[i*DW +: DW] = $urandom;
      ph_exp_b[i*DW +: DW] = $urandom;
    end
    r = $urandom;
    ph_add_start = r[NP*NA-1:0];
    ph_mult_start = r[8 +: NP];
    ph_exp_start = r[12 +: NP];
    ph_div_start = r[16 +: NP];
  endtask

  // phase k starts at s[k], waits wlen[k] cycles; a timed-out phase waits TO cycles then DONE
  task automatic run(input int to_ph, input bit stray);
    int s [NP];
    int d, wb, last, ka, prev;
    bit wexp;
    logic [NP-1:0] pd;
    logic [31:0] r;
    for (int i = 0; i < NE; i++) result_val[i*DW +: DW] = res[i];
    last = to_ph >= 0 ? to_ph : NP - 1;
    s[0] = NI + 2;
    for (int k = 1; k < NP; k++) s[k] = s[k-1] + wlen[k-1] + 1;
    wb = s[NP-1] + wlen[NP-1] + 1;
    d = to_ph >= 0 ? s[to_ph] + TO + 1 : wb + NE;
    @(posedge clock); #1;
    start = 1'b1;
    phase_done = '0;
    prev = 0;
    for (int t = 1; t <= d + 2; t++) begin
      @(posedge clock); #1;
      r = $urandom;
      start = stray && t <= d ? r[0] : 1'b0;
      rdata = prev < NI ? mem[prev] : $urandom;
      ka = -1;
      for (int k = 0; k <= last; k++)
        if (t >= s[k] && t <= s[k] + (k == to_ph ? TO : wlen[k])) ka = k;
      pd = stray ? r[4 +: NP] : '0;
      if (ka >= 0) pd[ka] = ka != to_ph && t == s[ka] + wlen[ka];
      phase_done = pd;
      wexp = to_ph < 0 && t >= wb && t < wb + NE;
      check("busy", 512'(busy), 512'(t <= d));
      check("data_ready", 512'(data_ready), 512'(t == d));
      check("phase_start", 512'(phase_start), 512'(ka >= 0 && t == s[ka] ? NP'(1) << ka : NP'(0)));
      check("timeout_err", 512'(timeout_err), 512'(to_ph >= 0 && t >= d));
      check("route", 512'(rgot), 512'(route(ka)));
      check("we", 512'(we), 512'(wexp));
      if (wexp) begin
        check("wb_addr", 512'(addr), 512'(NI + t - wb));
        check("wb_data", 512'(wdata), 512'(res[t - wb]));
      end
      if (t <= NI) check("fetch_addr", 512'(addr), 512'(t - 1));
      prev = int'(addr);
    end
    for (int k = 0; k < NI; k++) check("init_val", 512'(init_val[k*DW +: DW]), 512'(mem[k]));
  endtask

  initial begin
    int n, ready_at, nw, nps;
    logic [31:0] r;
    phase_done = '0; rdata = '0; result_val = '0; pd2 = 1'b0; rdata2 = '0; res2 = '0;
    pa2 = '0; pb2 = '0; pas2 = '0;
    rand_all();
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_ready", 512'(data_ready), 512'(0));
    check("rst_init", 512'(init_val), 512'(0));
    check("rst_addr", 512'(addr), 512'(0));
    check("rst_we", 512'(we), 512'(0));
    check("rst_route", 512'(rgot), 512'(0));
    reset = 1'b0;
    for (int i = 0; i < NI; i++) mem[i] = 32'h10 + i;
    for (int i = 0; i < NE; i++) res[i] = 32'hA0 + i;
    ph_add_a[(1*NA + 1)*DW +: DW] = 32'h1234;
    wlen = '{1, 1, 1};
    run(-1, 1'b0);
    repeat (4) begin
      rand_all();
      for (int k = 0; k < NP; k++) wlen[k] = $urandom_range(1, TO - 1);
      run(-1, 1'b1);
    end
    rand_all();
    wlen = '{1, 1, 1};
    run(1, 1'b0);
    rand_all();
    wlen = '{2, 1, 3};
    run(-1, 1'b0);
    @(posedge clock); #1;
    start = 1'b1;
    phase_done = '1;
    n = 0;
    @(posedge clock); #1;
    start = 1'b0;
    while (!we && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check("reach_wb", 512'(we), 512'(1));
    reset = 1'b1;
    @(posedge clock); #1;
    check("mid_rst_busy", 512'(busy), 512'(0));
    check("mid_rst_we", 512'(we), 512'(0));
    check("mid_rst_init", 512'(init_val), 512'(0));
    check("mid_rst_pstart", 512'(phase_start), 512'(0));
    reset = 1'b0;
    phase_done = '0;
    rand_all();
    wlen = '{1, 1, 1};
    run(-1, 1'b0);
    res2 = $urandom;
    rdata2 = $urandom;
    for (int i = 0; i < 4; i++) pa2[i*DW +: DW] = $urandom;
    r = $urandom;
    pas2 = r[3:0];
    pd2 = 1'b1;
    ready_at = -1; nw = 0; nps = 0;
    @(posedge clock); #1;
    start2 = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      @(posedge clock); #1;
      start2 = 1'b0;
      if (dr2) ready_at = t;
      if (we2) begin
        nw++;
        check("sw_addr", 512'(a2), 512'(1));
        check("sw_data", 512'(wdata2), 512'(res2));
      end
      if (ps2[0]) begin
        nps++;
        check("sw_route", 512'({add_a2, add_start2}), 512'({pa2, pas2}));
      end
    end
    check("sw_ready_cycle", 512'(ready_at), 512'(6));
    check("sw_writes", 512'(nw), 512'(1));
    check("sw_pstarts", 512'(nps), 512'(1));
    check("sw_init", 512'(init2), 512'(rdata2));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
